// File: rtl/crc_pkg.sv
// Shared constants for the serial CRC-8 generator.
// Width, reset/reseed value and feedback tap mask.
package crc_pkg;

  localparam int          CRC8_WIDTH = 8;
  localparam logic [7:0]  CRC8_SEED  = 8'hD8;
  localparam logic [7:0]  CRC8_TAPS  = 8'h44;

endpackage

// File: rtl/lfsr_crc8.sv
// Serial CRC-8: absorbs DATA (LSB first) while ACTIVE, then shifts CRC out.
// Ports: CLK, RST (async low), ACTIVE, DATA in; CRC, Valid registered out.
module lfsr_crc8
  import crc_pkg::*;
#(
  parameter int               WIDTH = CRC8_WIDTH,
  parameter logic [WIDTH-1:0] SEED  = CRC8_SEED,
  parameter logic [WIDTH-1:0] TAPS  = CRC8_TAPS
) (
  input  logic CLK,
  input  logic RST,
  input  logic ACTIVE,
  input  logic DATA,
  output logic CRC,
  output logic Valid
);

  localparam int CW = $clog2(WIDTH);

  // feedback lands in the MSB as well as the tapped bits
  localparam logic [WIDTH-1:0] FB_MASK =
    {1'b1, TAPS[WIDTH-2:0]};

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             armed_q, armed_d;
  logic             crc_q, crc_d;
  logic             vld_q, vld_d;

  logic [WIDTH-1:0] base;
  logic             fb;

  always_comb begin
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    crc_d   = 1'b0;
    vld_d   = 1'b0;
    // a nonzero count means output is in flight;
    // a new message then restarts from SEED
    base    = (cnt_q != '0) ? SEED : lfsr_q;
    fb      = DATA ^ base[0];
    if (ACTIVE) begin
      lfsr_d  = (base >> 1) ^ ({WIDTH{fb}} & FB_MASK);
      armed_d = 1'b1;
      cnt_d   = '0;
    end else if (armed_q) begin
      crc_d = lfsr_q[0];
      vld_d = 1'b1;
      if (cnt_q == LAST) begin
        lfsr_d  = SEED;
        cnt_d   = '0;
        armed_d = 1'b0;
      end else begin
        lfsr_d = lfsr_q >> 1;
        cnt_d  = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      lfsr_q  <= SEED;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      crc_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      crc_q   <= crc_d;
      vld_q   <= vld_d;
    end
  end

  assign CRC   = crc_q;
  assign Valid = vld_q;

endmodule

// File: tb/tb_lfsr_crc8.sv
// Self-checking bench for lfsr_crc8.
// Expected CRC bits are queued at stimulus time and popped on output.
module tb_lfsr_crc8;

  logic CLK = 1'b0;
  logic RST;
  logic ACTIVE;
  logic DATA;
  logic CRC;
  logic Valid;

  int n_tests = 0;
  int n_fail  = 0;

  logic exp_q[$];

  lfsr_crc8 dut (
    .CLK    (CLK),
    .RST    (RST),
    .ACTIVE (ACTIVE),
    .DATA   (DATA),
    .CRC    (CRC),
    .Valid  (Valid)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] model(
    input logic [31:0] msg,
    input int          n
  );
    logic [7:0] r;
    logic       f;
    r = 8'hD8;
    for (int i = 0; i < n; i++) begin
      f = msg[i] ^ r[0];
      r = r >> 1;
      if (f) r = r ^ 8'hC4;
    end
    return r;
  endfunction

  task automatic push_exp(input logic [7:0] c);
    for (int k = 0; k < 8; k++) exp_q.push_back(c[k]);
  endtask

  task automatic send_bits(
    input logic [31:0] msg,
    input int          n
  );
    push_exp(model(msg, n));
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      ACTIVE = 1'b1;
      DATA   = msg[i];
    end
    @(negedge CLK);
    ACTIVE = 1'b0;
    DATA   = 1'b0;
  endtask

  task automatic collect(
    input  string      name,
    input  int         n,
    output logic [7:0] got
  );
    logic e;
    got = '0;
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
      got[k] = CRC;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s bit%0d: queue empty", name, k);
        e = 1'b0;
      end else begin
        e = exp_q.pop_front();
      end
      if (Valid !== 1'b1 || CRC !== e) begin
        n_fail++;
        $display("FAIL %s bit%0d: Valid=%b CRC=%b want 1/%b",
                 name, k, Valid, CRC, e);
      end
    end
  endtask

  task automatic check_idle(input string name);
    @(posedge CLK);
    #1;
    n_tests++;
    if (Valid !== 1'b0 || CRC !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle: Valid=%b CRC=%b want 0/0",
               name, Valid, CRC);
    end
  endtask

  task automatic check_byte(
    input string      name,
    input logic [7:0] got,
    input logic [7:0] want
  );
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s crc: got %h want %h", name, got, want);
    end
  endtask

  task automatic test_reset();
    RST    = 1'b0;
    ACTIVE = 1'b0;
    DATA   = 1'b0;
    @(posedge CLK);
    #1;
    n_tests++;
    if (Valid !== 1'b0 || CRC !== 1'b0 || dut.lfsr_q !== 8'hD8) begin
      n_fail++;
      $display("FAIL reset: Valid=%b CRC=%b lfsr=%h want 0/0/d8",
               Valid, CRC, dut.lfsr_q);
    end
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 6; i++) check_idle("reset_quiet");
  endtask

  task automatic test_zero();
    logic [7:0] g;
    send_bits(32'h00, 8);
    collect("zero", 8, g);
    check_byte("zero", g, 8'h14);
    check_idle("zero_end");
  endtask

  task automatic test_ones();
    logic [7:0] g;
    send_bits(32'hFF, 8);
    collect("ones", 8, g);
    check_byte("ones", g, 8'h72);
    check_idle("ones_end");
  endtask

  task automatic test_back_to_back();
    logic [7:0] g;
    send_bits(32'h00, 8);
    collect("b2b_a", 8, g);
    check_byte("b2b_a", g, 8'h14);
    send_bits(32'hFF, 8);
    collect("b2b_b", 8, g);
    check_byte("b2b_b", g, 8'h72);
    check_idle("b2b_end");
  endtask

  task automatic test_lengths();
    logic [7:0]  g;
    logic [31:0] m;
    int          n;
    for (int t = 0; t < 6; t++) begin
      m = $urandom;
      n = (t == 0) ? 1 : $urandom_range(2, 24);
      send_bits(m, n);
      collect("len", 8, g);
      check_idle("len_end");
    end
  endtask

  task automatic test_abort();
    logic [7:0] g;
    send_bits(32'h00, 8);
    collect("abort_pre", 3, g);
    @(negedge CLK);
    ACTIVE = 1'b1;
    DATA   = 1'b0;
    @(posedge CLK);
    #1;
    n_tests++;
    if (Valid !== 1'b0 || CRC !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_edge: Valid=%b CRC=%b want 0/0",
               Valid, CRC);
    end
    exp_q.delete();
    push_exp(model(32'h00, 8));
    for (int i = 1; i < 8; i++) begin
      @(negedge CLK);
      ACTIVE = 1'b1;
      DATA   = 1'b0;
    end
    @(negedge CLK);
    ACTIVE = 1'b0;
    collect("abort_new", 8, g);
    check_byte("abort_new", g, 8'h14);
    check_idle("abort_end");
  endtask

  task automatic test_async_reset();
    logic [7:0] g;
    send_bits(32'hFF, 8);
    collect("arst_pre", 3, g);
    #2;
    RST = 1'b0;
    #1;
    n_tests++;
    if (Valid !== 1'b0 || CRC !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_async: Valid=%b CRC=%b want 0/0",
               Valid, CRC);
    end
    exp_q.delete();
    @(negedge CLK);
    RST = 1'b1;
    n_tests++;
    if (dut.lfsr_q !== 8'hD8) begin
      n_fail++;
      $display("FAIL arst_lfsr: got %h want d8", dut.lfsr_q);
    end
    for (int i = 0; i < 4; i++) check_idle("arst_quiet");
    send_bits(32'h00, 8);
    collect("arst_after", 8, g);
    check_byte("arst_after", g, 8'h14);
  endtask

  initial begin
    test_reset();
    test_zero();
    test_ones();
    test_back_to_back();
    test_lengths();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
